// File: rtl/pu_write_serializer_pkg.sv
// Shared parameters and helpers for the PU write serializer.
//   P_*      : default parameter values of the serializer
//   c_log_2  : number of bits needed to index n items (at least 1)
package pu_write_serializer_pkg;

   localparam int unsigned P_OP_WIDTH   = 16;
   localparam int unsigned P_NUM_PE     = 8;
   localparam int unsigned P_OUT_WIDTH  = 64;
   localparam int unsigned P_FIFO_DEPTH = 4;
   localparam int unsigned P_CNT_W      = 16;

   // Index width for n entries; a single entry still gets one bit.
   function automatic int unsigned c_log_2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/pu_wr_fifo.sv
// Vector FIFO for the PU write serializer. Register-array storage; the head
// entry is read straight from the array so a push into an empty FIFO is
// visible on the following cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_flush     : synchronous clear of pointers and occupancy
//   i_push      : write i_data at the tail (ignored while full)
//   i_pop       : drop the head entry (ignored while empty)
//   o_data      : head entry
//   o_full      : occupancy == DEPTH
//   o_empty     : occupancy == 0
//   o_count     : occupancy, log2(DEPTH)+1 bits
module pu_wr_fifo
   import pu_write_serializer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_flush,
   input  logic                             i_push,
   input  logic [DATA_WIDTH-1:0]            i_data,
   input  logic                             i_pop,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [c_log_2(DEPTH):0]          o_count
);

   localparam int unsigned PTR_W = c_log_2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [OCC_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   assign o_full  = (r_count == OCC_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Pointers wrap naturally (DEPTH is a power of two); flush wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/pu_write_serializer.sv
// Buffers PU output vectors and serializes each into OUT_WIDTH-bit beats,
// LSB beat first, on a valid/ready stream towards the memory write path.
//   clk, reset      : clock, asynchronous active-low reset
//   flush           : sync clear of FIFO, beat counter and overflow flag
//   pu_write_data   : PU output vector (NUM_PE*OP_WIDTH)
//   pu_write_req    : PU write strobe
//   pu_write_ready  : FIFO not full (low while in reset)
//   wr_data         : current beat (0 when no beat is valid)
//   wr_valid        : beat valid
//   wr_last         : beat is the last of its vector
//   wr_ready        : sink accepts beat
//   vec_out_count   : vectors fully sent since reset; wraps
//   overflow        : sticky, set by a req while not ready
//   idle            : FIFO empty and beat counter at 0
module pu_write_serializer
   import pu_write_serializer_pkg::*;
#(
   parameter int unsigned OP_WIDTH   = P_OP_WIDTH,
   parameter int unsigned NUM_PE     = P_NUM_PE,
   parameter int unsigned OUT_WIDTH  = P_OUT_WIDTH,
   parameter int unsigned FIFO_DEPTH = P_FIFO_DEPTH,
   parameter int unsigned CNT_W      = P_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [NUM_PE*OP_WIDTH-1:0]   pu_write_data,
   input  logic                         pu_write_req,
   output logic                         pu_write_ready,
   output logic [OUT_WIDTH-1:0]         wr_data,
   output logic                         wr_valid,
   output logic                         wr_last,
   input  logic                         wr_ready,
   output logic [CNT_W-1:0]             vec_out_count,
   output logic                         overflow,
   output logic                         idle
);

   localparam int unsigned DATA_WIDTH = NUM_PE * OP_WIDTH;
   localparam int unsigned BEATS      = DATA_WIDTH / OUT_WIDTH;
   localparam int unsigned OCC_W      = c_log_2(FIFO_DEPTH) + 1;

   logic                  w_full;
   logic                  w_empty;
   logic [OCC_W-1:0]      w_occ;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_xfer;
   logic                  w_pop;
   logic                  w_last_beat;
   logic                  w_beat_zero;
   logic [OUT_WIDTH-1:0]  w_beat_data;
   logic                  r_ready_en;
   logic                  r_overflow;
   logic [CNT_W-1:0]      r_vec_cnt;

   pu_wr_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_flush (flush),
      .i_push  (pu_write_req & pu_write_ready),
      .i_data  (pu_write_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_occ)
   );

   // Registered enable keeps ready low through reset without using the
   // reset pin as data.
   assign pu_write_ready = r_ready_en & ~w_full;
   assign wr_valid       = ~w_empty;
   assign w_xfer         = wr_valid & wr_ready;
   assign w_pop          = w_xfer & w_last_beat & ~flush;
   assign wr_last        = wr_valid & w_last_beat;
   assign wr_data        = wr_valid ? w_beat_data : '0;
   assign idle           = (w_occ == '0) & w_beat_zero;
   assign vec_out_count  = r_vec_cnt;
   assign overflow       = r_overflow;

   // Beat selection; a single-beat vector needs no counter.
   if (BEATS == 1) begin : g_one_beat
      assign w_beat_data = w_head;
      assign w_last_beat = 1'b1;
      assign w_beat_zero = 1'b1;
   end else begin : g_multi_beat
      localparam int unsigned BEAT_W = c_log_2(BEATS);
      logic [BEAT_W-1:0] r_beat;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_beat <= '0;
         end else if (flush) begin
            r_beat <= '0;
         end else if (w_xfer) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
         end
      end

      assign w_beat_data = w_head[32'(r_beat) * OUT_WIDTH +: OUT_WIDTH];
      assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
      assign w_beat_zero = (r_beat == '0);
   end

   // Ready enable, overflow flag and completed-vector counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready_en <= 1'b0;
         r_overflow <= 1'b0;
         r_vec_cnt  <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (flush) begin
            r_overflow <= 1'b0;
         end else if (pu_write_req && !pu_write_ready) begin
            r_overflow <= 1'b1;
         end
         if (w_pop) r_vec_cnt <= r_vec_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pu_write_serializer.sv
// Bench for pu_write_serializer: a 2-beat instance (NUM_PE=8) and a 1-beat
// instance (NUM_PE=4) share clock and reset. Expected beats are queued when
// a vector is driven and compared as the sink accepts them.
module tb_pu_write_serializer;

   logic         clk = 1'b0;
   logic         reset;

   logic         flush0, req0, rdy0, valid0, last0, wr_ready0, ovf0, idle0;
   logic [127:0] data0;
   logic [63:0]  wr_data0;
   logic [15:0]  cnt0;

   logic         flush1, req1, rdy1, valid1, last1, wr_ready1, ovf1, idle1;
   logic [63:0]  data1;
   logic [63:0]  wr_data1;
   logic [15:0]  cnt1;

   int           n_checks = 0;
   int           n_pass   = 0;
   int           beats0   = 0;
   logic [64:0]  q0[$];
   logic [64:0]  q1[$];
   logic [64:0]  e0, e1;

   always #5 clk = ~clk;

   pu_write_serializer u_dut0 (
      .clk(clk), .reset(reset), .flush(flush0),
      .pu_write_data(data0), .pu_write_req(req0), .pu_write_ready(rdy0),
      .wr_data(wr_data0), .wr_valid(valid0), .wr_last(last0), .wr_ready(wr_ready0),
      .vec_out_count(cnt0), .overflow(ovf0), .idle(idle0)
   );

   pu_write_serializer #(.NUM_PE(4)) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush1),
      .pu_write_data(data1), .pu_write_req(req1), .pu_write_ready(rdy1),
      .wr_data(wr_data1), .wr_valid(valid1), .wr_last(last1), .wr_ready(wr_ready1),
      .vec_out_count(cnt1), .overflow(ovf1), .idle(idle1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Sink-side scoreboards: a beat is taken when valid && ready before the edge.
   always @(negedge clk) begin
      if (valid0 && wr_ready0) begin
         if (q0.size() == 0) begin
            chk("mon0_extra_beat", 64'(q0.size()), 64'd1);
         end else begin
            e0 = q0.pop_front();
            chk("mon0_data", wr_data0, e0[63:0]);
            chk("mon0_last", 64'(last0), 64'(e0[64]));
            beats0++;
         end
      end
   end

   always @(negedge clk) begin
      if (valid1 && wr_ready1) begin
         if (q1.size() == 0) begin
            chk("mon1_extra_beat", 64'(q1.size()), 64'd1);
         end else begin
            e1 = q1.pop_front();
            chk("mon1_data", wr_data1, e1[63:0]);
            chk("mon1_last", 64'(last1), 64'(e1[64]));
         end
      end
   end

   // Drives one request cycle (req left high); queues beats if it should be taken.
   task automatic push0(input logic [127:0] v, input logic exp_rdy);
      @(posedge clk); #1;
      req0  = 1'b1;
      data0 = v;
      @(negedge clk);
      chk("push0_ready", 64'(rdy0), 64'(exp_rdy));
      if (exp_rdy) begin
         q0.push_back({1'b0, v[63:0]});
         q0.push_back({1'b1, v[127:64]});
      end
   endtask

   task automatic push1(input logic [63:0] v, input logic exp_rdy);
      @(posedge clk); #1;
      req1  = 1'b1;
      data1 = v;
      @(negedge clk);
      chk("push1_ready", 64'(rdy1), 64'(exp_rdy));
      if (exp_rdy) q1.push_back({1'b1, v});
   endtask

   task automatic drain0();
      bit done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (q0.size() == 0 && !valid0 && idle0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain0_done", 64'(done), 64'd1);
   endtask

   task automatic drain1();
      bit done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (q1.size() == 0 && !valid1 && idle1) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain1_done", 64'(done), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [127:0] v;
      logic [63:0]  v1;
      logic [63:0]  held_d;
      logic         held_l;
      bit           prev_stall;
      int           start;

      reset = 1'b0;
      flush0 = 1'b0; req0 = 1'b0; data0 = '0; wr_ready0 = 1'b0;
      flush1 = 1'b0; req1 = 1'b0; data1 = '0; wr_ready1 = 1'b0;

      // Reset then idle
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(valid0), 64'd0);
      chk("rst_ready", 64'(rdy0), 64'd0);
      chk("rst_ready1", 64'(rdy1), 64'd0);
      chk("rst_data", wr_data0, 64'd0);
      chk("rst_last", 64'(last0), 64'd0);
      chk("rst_idle", 64'(idle0), 64'd1);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", 64'(rdy0), 64'd1);
      chk("post_rst_idle", 64'(idle0), 64'd1);
      chk("post_rst_count", 64'(cnt0), 64'd0);
      chk("post_rst_ovf", 64'(ovf0), 64'd0);

      // Single vector, sink always ready
      @(posedge clk); #1 wr_ready0 = 1'b1;
      for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(i);
      push0(v, 1'b1);
      @(posedge clk); #1 req0 = 1'b0;
      @(negedge clk);
      chk("t2_valid", 64'(valid0), 64'd1);
      chk("t2_beat0", wr_data0, 64'h0003000200010000);
      chk("t2_last0", 64'(last0), 64'd0);
      @(negedge clk);
      chk("t2_beat1", wr_data0, 64'h0007000600050004);
      chk("t2_last1", 64'(last0), 64'd1);
      drain0();
      chk("t2_count", 64'(cnt0), 64'd1);

      // Back-pressure: six back-to-back requests into a four-deep FIFO
      @(posedge clk); #1 wr_ready0 = 1'b0;
      start = beats0;
      for (int k = 0; k < 6; k++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         push0(v, 1'(k < 4));
      end
      @(posedge clk); #1 req0 = 1'b0;
      @(negedge clk);
      chk("t3_overflow", 64'(ovf0), 64'd1);
      chk("t3_full_ready", 64'(rdy0), 64'd0);
      @(posedge clk); #1 wr_ready0 = 1'b1;
      drain0();
      chk("t3_beats", 64'(beats0 - start), 64'd8);
      chk("t3_count", 64'(cnt0), 64'd5);

      // Stall stability with a toggling sink
      @(posedge clk); #1 wr_ready0 = 1'b0;
      start = beats0;
      for (int k = 0; k < 2; k++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         push0(v, 1'b1);
      end
      @(posedge clk); #1 req0 = 1'b0;
      prev_stall = 1'b0;
      held_d = '0;
      held_l = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1 wr_ready0 = (i % 2 == 0);
         @(negedge clk);
         if (prev_stall) begin
            chk("t4_stall_data", wr_data0, held_d);
            chk("t4_stall_last", 64'(last0), 64'(held_l));
         end
         prev_stall = valid0 && !wr_ready0;
         held_d = wr_data0;
         held_l = last0;
      end
      @(posedge clk); #1 wr_ready0 = 1'b1;
      drain0();
      chk("t4_beats", 64'(beats0 - start), 64'd4);
      chk("t4_count", 64'(cnt0), 64'd7);

      // Single-beat instance: steady push/pop at occupancy 2
      @(posedge clk); #1 wr_ready1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         v1 = {$urandom(), $urandom()};
         push1(v1, 1'b1);
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         req1 = 1'b1;
         data1 = {$urandom(), $urandom()};
         wr_ready1 = 1'b1;
         @(negedge clk);
         chk("t5_occ", 64'(u_dut1.u_fifo.r_count), 64'd2);
         chk("t5_ready", 64'(rdy1), 64'd1);
         q1.push_back({1'b1, data1});
      end
      @(posedge clk); #1;
      req1 = 1'b0;
      wr_ready1 = 1'b0;
      @(negedge clk);
      chk("t5_count", 64'(cnt1), 64'd20);
      chk("t5_ovf", 64'(ovf1), 64'd0);
      chk("t5_occ_end", 64'(u_dut1.u_fifo.r_count), 64'd2);
      @(posedge clk); #1 wr_ready1 = 1'b1;
      drain1();
      chk("t5_count_drained", 64'(cnt1), 64'd22);

      // Flush after beat 0 of a vector
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      push0(v, 1'b1);
      @(posedge clk); #1 req0 = 1'b0;
      @(negedge clk);
      chk("t6_ovf_sticky", 64'(ovf0), 64'd1);
      @(posedge clk); #1;
      flush0 = 1'b1;
      wr_ready0 = 1'b0;
      @(negedge clk);
      chk("t6_pre_flush_beat1", wr_data0, v[127:64]);
      @(posedge clk); #1 flush0 = 1'b0;
      @(negedge clk);
      chk("t6_flush_valid", 64'(valid0), 64'd0);
      chk("t6_flush_idle", 64'(idle0), 64'd1);
      chk("t6_flush_ovf", 64'(ovf0), 64'd0);
      chk("t6_flush_count", 64'(cnt0), 64'd7);
      q0.delete();

      // FIFO usable again after flush
      @(posedge clk); #1 wr_ready0 = 1'b1;
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      push0(v, 1'b1);
      @(posedge clk); #1 req0 = 1'b0;
      drain0();
      chk("t6_after_flush_count", 64'(cnt0), 64'd8);

      // Reset after beat 0 of a vector
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      push0(v, 1'b1);
      @(posedge clk); #1 req0 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      wr_ready0 = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid", 64'(valid0), 64'd0);
      chk("t6_rst_idle", 64'(idle0), 64'd1);
      chk("t6_rst_count", 64'(cnt0), 64'd0);
      chk("t6_rst_count1", 64'(cnt1), 64'd0);
      chk("t6_rst_ready", 64'(rdy0), 64'd0);
      q0.delete();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t6_rel_ready", 64'(rdy0), 64'd1);
      chk("t6_rel_idle", 64'(idle0), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
